// File: rtl/qed_replay_buffer.sv
// QED replay stage: passes fetched instructions to decode while recording them, then replays
// them with registers remapped into the upper half of the register file.
module qed_replay_buffer #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exec_dup,
   input  logic [31:0]       ifu_instr,
   input  logic              ifu_valid,
   output logic              ifu_ready,
   output logic [31:0]       qed_instr,
   output logic              qed_valid,
   output logic              qed_is_dup,
   input  logic              qed_ready,
   input  logic              commit,
   input  logic              commit_is_dup,
   output logic [ADDR_W:0]   qed_num_orig,
   output logic [ADDR_W:0]   qed_num_dup,
   output logic              qed_check_valid,
   output logic              qed_err
);

   typedef enum logic [1:0] {StOrig, StDup, StDone} state_e;

   localparam logic [ADDR_W:0] DepthC = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] OneC   = (ADDR_W + 1)'(1);

   state_e              state_q;
   logic [ADDR_W-1:0]   head_q, tail_q;
   logic [ADDR_W:0]     count_q, count_nxt;
   logic [ADDR_W:0]     num_orig_q, num_dup_q, pushes_q;
   logic                err_q, err_set;
   logic [31:0]         fifo_q [DEPTH];
   logic                push, pop, orig_inc, dup_inc;

   // Move x1..x15 to x17..x31 in every register field the opcode actually uses.
   function automatic logic [31:0] remap(input logic [31:0] i);
      logic [31:0] r;
      logic        rd_u, rs1_u, rs2_u;
      r     = i;
      rd_u  = 1'b0;
      rs1_u = 1'b0;
      rs2_u = 1'b0;
      case (i[6:0])
         7'b0110011:             begin rd_u = 1'b1; rs1_u = 1'b1; rs2_u = 1'b1; end
         7'b0010011, 7'b0000011: begin rd_u = 1'b1; rs1_u = 1'b1; end
         7'b0100011:             begin rs1_u = 1'b1; rs2_u = 1'b1; end
         7'b0110111, 7'b0010111: rd_u = 1'b1;
         default: ;
      endcase
      if (rd_u  && i[11:7]  != 5'd0) r[11:7]  = i[11:7]  + 5'd16;
      if (rs1_u && i[19:15] != 5'd0) r[19:15] = i[19:15] + 5'd16;
      if (rs2_u && i[24:20] != 5'd0) r[24:20] = i[24:20] + 5'd16;
      return r;
   endfunction

   always_comb begin
      ifu_ready  = 1'b0;
      qed_valid  = 1'b0;
      qed_instr  = ifu_instr;
      qed_is_dup = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      unique case (state_q)
         StOrig: begin
            ifu_ready = (count_q != DepthC);
            qed_valid = ifu_valid & ifu_ready;
            push      = qed_valid & qed_ready;
         end
         StDup: begin
            qed_valid  = (count_q != '0);
            qed_instr  = remap(fifo_q[head_q]);
            qed_is_dup = 1'b1;
            pop        = qed_valid & qed_ready;
         end
         default: ;
      endcase
   end

   always_comb begin
      count_nxt = count_q;
      if (push)     count_nxt = count_q + OneC;
      else if (pop) count_nxt = count_q - OneC;
   end

   assign orig_inc = commit & ~commit_is_dup;
   assign dup_inc  = commit & commit_is_dup;

   assign err_set = (dup_inc && state_q == StOrig)
                  | (dup_inc && num_dup_q >= num_orig_q)
                  | (orig_inc && state_q == StDone && num_orig_q == pushes_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StOrig;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         num_orig_q <= '0;
         num_dup_q  <= '0;
         pushes_q   <= '0;
         err_q      <= 1'b0;
         for (int k = 0; k < int'(DEPTH); k++) fifo_q[k] <= '0;
      end else begin
         count_q <= count_nxt;
         if (push) begin
            fifo_q[tail_q] <= ifu_instr;
            tail_q         <= tail_q + 1'b1;
            pushes_q       <= pushes_q + OneC;
         end
         if (pop) head_q <= head_q + 1'b1;
         unique case (state_q)
            StOrig: if ((exec_dup && count_nxt != '0) || count_nxt == DepthC) state_q <= StDup;
            StDup:  if (pop && count_nxt == '0) state_q <= StDone;
            default: ;
         endcase
         if (orig_inc && num_orig_q != DepthC) num_orig_q <= num_orig_q + OneC;
         if (dup_inc && num_dup_q != DepthC)   num_dup_q  <= num_dup_q + OneC;
         if (err_set) err_q <= 1'b1;
      end
   end

   assign qed_num_orig    = num_orig_q;
   assign qed_num_dup     = num_dup_q;
   assign qed_err         = err_q;
   assign qed_check_valid = (state_q == StDone) && (num_orig_q == num_dup_q) && (num_orig_q != '0);

endmodule
